// File: rtl/output_bram_axis_tx_pkg.sv
// Shared definitions for the result-BRAM AXI4-Stream transmitter.
// Holds the FSM encoding, the BRAM read latency and a ceil-log2 helper.
// Used by the top level and its output FIFO.
package output_bram_axis_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_READ  = 2'd1,
    TX_DRAIN = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_t;

  // Cycles from read issue to data appearing on the BRAM output port
  localparam int BRAM_READ_LATENCY = 2;

  // Ceiling log2; clogb2(1) = 0
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the stream output.
// Latency: a push is visible on dout the cycle after the write edge.
// No internal backpressure: the caller guarantees it never pushes when full.
module axis_tx_fifo
  import output_bram_axis_tx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [clogb2(DEPTH):0] count
);

  localparam int AW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  // Head word is forced to zero when empty so the stream data is clean at idle
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/output_bram_axis_tx.sv
// Streams a contiguous run of result-BRAM words out as an AXI4-Stream master.
// Latency: start sampled in cycle 0, first beat valid in cycle 4, then 1 beat/cycle.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads has room.
module output_bram_axis_tx
  import output_bram_axis_tx_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH    = 32,
  parameter int BRAM_ADDRESS_WIDTH = 9,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          transfer_start,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] start_address,
  input  logic [11:0]                   word_count,
  input  logic                          abort,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_address_B,
  output logic                          bram_B_en,
  output logic                          bram_B_wen,
  input  logic [BRAM_DATA_WIDTH-1:0]    data_from_bram_B,
  output logic [BRAM_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          transfer_done,
  output logic [1:0]                    tx_state_o
);

  localparam int CW = clogb2(FIFO_DEPTH) + 1;

  tx_state_t                     state;
  tx_state_t                     state_nxt;
  logic [11:0]                   count_q;
  logic [11:0]                   issued;
  logic [11:0]                   sent;
  logic [BRAM_ADDRESS_WIDTH-1:0] addr;
  logic [BRAM_READ_LATENCY-1:0]  rd_pipe;   // one valid bit per read still in the BRAM pipeline
  logic [CW-1:0]                 fifo_cnt;
  logic                          fifo_empty;
  logic                          pop;
  logic                          last_beat;
  int                            credit_used;

  assign bram_B_wen     = 1'b0;
  assign bram_address_B = addr;
  assign m_axis_tvalid  = ~fifo_empty;
  assign pop            = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast   = m_axis_tvalid & (sent == count_q - 12'd1);
  assign last_beat      = pop & m_axis_tlast;
  assign busy           = (state != TX_IDLE);
  assign transfer_done  = (state == TX_DONE);
  assign tx_state_o     = state;

  // Registered occupancy plus reads not yet landed; a same-cycle pop is not credited
  always_comb begin
    credit_used = int'(fifo_cnt) + $countones(rd_pipe);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and read-issue gating; abort overrides everything
  always_comb begin
    state_nxt = state;
    bram_B_en = 1'b0;
    case (state)
      TX_IDLE: begin
        if (transfer_start) state_nxt = (word_count == 12'd0) ? TX_DONE : TX_READ;
      end
      TX_READ: begin
        bram_B_en = (issued < count_q) && (credit_used < FIFO_DEPTH);
        if (bram_B_en && (issued == count_q - 12'd1)) state_nxt = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (last_beat) state_nxt = TX_DONE;
      end
      TX_DONE: state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
    if (abort) state_nxt = TX_IDLE;
  end

  // Transfer counters, read address and the in-flight read tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      issued  <= '0;
      sent    <= '0;
      addr    <= '0;
      rd_pipe <= '0;
    end else if (abort) begin
      // Killing the pipeline bits drops any read data still on its way back
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[BRAM_READ_LATENCY-2:0], bram_B_en};
      if (state == TX_IDLE && transfer_start) begin
        count_q <= word_count;
        addr    <= start_address;
        issued  <= '0;
        sent    <= '0;
      end else begin
        if (bram_B_en) begin
          addr   <= addr + BRAM_ADDRESS_WIDTH'(1);
          issued <= issued + 12'd1;
        end
        if (pop) sent <= sent + 12'd1;
      end
    end
  end

  axis_tx_fifo #(
    .WIDTH (BRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst | abort),
    .push  (rd_pipe[BRAM_READ_LATENCY-1]),
    .pop   (pop),
    .din   (data_from_bram_B),
    .dout  (m_axis_tdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_output_bram_axis_tx.sv
// Directed bench for output_bram_axis_tx with a 2-cycle-latency BRAM model.
// A negedge monitor records issued addresses, stream beats and done pulses.
// Expected streams come from the known BRAM fill pattern 0x100 + address.
module tb_output_bram_axis_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer_start;
  logic [8:0]  start_address;
  logic [11:0] word_count;
  logic        abort;
  logic [8:0]  bram_address_B;
  logic        bram_B_en;
  logic        bram_B_wen;
  logic [31:0] data_from_bram_B;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        transfer_done;
  logic [1:0]  tx_state_o;

  always #5 clk = ~clk;

  output_bram_axis_tx #(
    .BRAM_DATA_WIDTH(32), .BRAM_ADDRESS_WIDTH(9), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .transfer_start(transfer_start),
    .start_address(start_address), .word_count(word_count), .abort(abort),
    .bram_address_B(bram_address_B), .bram_B_en(bram_B_en), .bram_B_wen(bram_B_wen),
    .data_from_bram_B(data_from_bram_B), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .transfer_done(transfer_done),
    .tx_state_o(tx_state_o)
  );

  // BRAM model: address registered on issue, data registered once more
  logic [31:0] bram [512];
  logic [31:0] rd1;
  initial for (int i = 0; i < 512; i++) bram[i] = 32'h100 + 32'(i);
  always @(posedge clk) begin
    if (bram_B_en) rd1 <= bram[bram_address_B];
    data_from_bram_B <= rd1;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  logic [31:0] dat_q [$];
  logic        last_q[$];
  int          bcyc_q[$];
  int          done_q[$];
  logic [8:0]  iss_q [$];
  int          tv_seen;
  int          outstanding;
  bit          mon_chk;
  bit          stalled;
  logic [31:0] stall_dat;
  logic        stall_last;

  always @(negedge clk) begin
    if (bram_B_en) begin
      iss_q.push_back(bram_address_B);
      outstanding++;
    end
    if (m_axis_tvalid) tv_seen++;
    if (m_axis_tvalid && m_axis_tready) begin
      dat_q.push_back(m_axis_tdata);
      last_q.push_back(m_axis_tlast);
      bcyc_q.push_back(cyc);
      outstanding--;
    end
    if (transfer_done) done_q.push_back(cyc);
    if (mon_chk) begin
      if (stalled) begin
        chk("stall_vld", 32'(m_axis_tvalid), 32'd1);
        chk("stall_dat", m_axis_tdata, stall_dat);
        chk("stall_last", 32'(m_axis_tlast), 32'(stall_last));
      end
      chk("credit_le_depth", (outstanding <= 4) ? 32'd1 : 32'd0, 32'd1);
    end
    stalled    = m_axis_tvalid && !m_axis_tready;
    stall_dat  = m_axis_tdata;
    stall_last = m_axis_tlast;
  end

  task automatic clear_mon();
    dat_q.delete(); last_q.delete(); bcyc_q.delete(); done_q.delete(); iss_q.delete();
    tv_seen = 0; outstanding = 0; stalled = 0;
  endtask

  task automatic start_xfer(input int a, input int n);
    @(posedge clk); #1;
    transfer_start = 1'b1;
    start_address  = 9'(a);
    word_count     = 12'(n);
    t0 = cyc;
    @(posedge clk); #1;
    transfer_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(posedge clk); #1;
      if (toggle) m_axis_tready = ~m_axis_tready;
      n++;
    end
    if (done_q.size() == 0) chk({tag, "_done_timeout"}, 32'(done_q.size()), 32'd1);
  endtask

  // Compares recorded beats against BRAM words base..base+n-1 (address wraps at 512)
  task automatic check_stream(input string tag, input int base, input int n);
    chk({tag, "_beats"}, 32'(dat_q.size()), 32'(n));
    for (int i = 0; i < n && i < dat_q.size(); i++) begin
      chk({tag, "_dat"}, dat_q[i], 32'h100 + 32'((base + i) % 512));
      chk({tag, "_last"}, 32'(last_q[i]), (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; transfer_start = 1'b0; start_address = '0; word_count = '0;
    abort = 1'b0; m_axis_tready = 1'b1; mon_chk = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en",    32'(bram_B_en),     32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast),  32'd0);
    chk("rst_tdata", m_axis_tdata,       32'd0);
    chk("rst_done",  32'(transfer_done), 32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_state", 32'(tx_state_o),    32'd0);
    chk("rst_wen",   32'(bram_B_wen),    32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic: 4 words from 0, tready high
    clear_mon(); mon_chk = 1'b1; m_axis_tready = 1'b1;
    start_xfer(0, 4);
    @(negedge clk);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 40, 1'b0);
    @(negedge clk);
    chk("basic_idle", 32'(tx_state_o), 32'd0);
    check_stream("basic", 0, 4);
    for (int i = 0; i < 4 && i < bcyc_q.size(); i++)
      chk("basic_beat_cycle", 32'(bcyc_q[i] - t0), 32'(4 + i));
    chk("basic_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("basic_done_cycle", 32'(done_q[0] - t0), 32'd8);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      chk("basic_addr", 32'(iss_q[i]), 32'(i));

    // Backpressure: 8 words, tready toggling every cycle
    clear_mon(); m_axis_tready = 1'b1;
    start_xfer(0, 8);
    wait_done("bp", 100, 1'b1);
    m_axis_tready = 1'b1;
    check_stream("bp", 0, 8);
    chk("bp_ndone", 32'(done_q.size()), 32'd1);

    // Zero length: only a done pulse in cycle 1
    clear_mon();
    start_xfer(0, 0);
    repeat (4) @(posedge clk);
    chk("zero_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("zero_done_cycle", 32'(done_q[0] - t0), 32'd1);
    chk("zero_issues", 32'(iss_q.size()), 32'd0);
    chk("zero_tvalid", 32'(tv_seen), 32'd0);

    // Address wrap: 0x1FE, 0x1FF, 0x000, 0x001
    clear_mon();
    start_xfer(9'h1FE, 4);
    wait_done("wrap", 40, 1'b0);
    check_stream("wrap", 9'h1FE, 4);
    chk("wrap_nissue", 32'(iss_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      chk("wrap_addr", 32'(iss_q[i]), 32'((9'h1FE + i) % 512));

    // Abort after two beats with the stream stalled
    clear_mon(); mon_chk = 1'b0; m_axis_tready = 1'b1;
    start_xfer(0, 16);
    begin
      int n;
      n = 0;
      while (dat_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    end
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_busy",   32'(busy),          32'd0);
    chk("abort_beats",  32'(dat_q.size()),  32'd2);
    repeat (4) @(posedge clk);
    chk("abort_ndone", 32'(done_q.size()), 32'd0);
    m_axis_tready = 1'b1;
    clear_mon(); mon_chk = 1'b1;
    start_xfer(9'h010, 2);
    wait_done("post_abort", 40, 1'b0);
    repeat (2) @(posedge clk);
    check_stream("post_abort", 9'h010, 2);

    // Start re-pulsed mid-transfer is ignored
    clear_mon(); m_axis_tready = 1'b1;
    start_xfer(0, 8);
    @(posedge clk); #1;
    transfer_start = 1'b1; start_address = 9'h050; word_count = 12'd2;
    @(posedge clk); #1 transfer_start = 1'b0;
    wait_done("restart", 60, 1'b0);
    repeat (3) @(posedge clk);
    check_stream("restart", 0, 8);
    chk("restart_ndone", 32'(done_q.size()), 32'd1);

    // Reset mid-DRAIN with the stream stalled
    clear_mon(); mon_chk = 1'b0; m_axis_tready = 1'b0;
    start_xfer(0, 3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pre_state", 32'(tx_state_o), 32'd2);
    chk("rst_mid_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mid_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_mid_tdata",  m_axis_tdata,       32'd0);
    chk("rst_mid_busy",   32'(busy),          32'd0);
    chk("rst_mid_state",  32'(tx_state_o),    32'd0);
    chk("rst_mid_en",     32'(bram_B_en),     32'd0);
    clear_mon(); m_axis_tready = 1'b1;
    repeat (6) @(posedge clk);
    chk("rst_mid_no_beats", 32'(dat_q.size()), 32'd0);
    chk("rst_mid_no_done",  32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
